// File: rtl/time_edit_pkg.sv
// Shared definitions for the clock's HH:MM edit path: FSM states,
// cursor positions and per-digit BCD maxima.
package time_edit_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] POS_HT = 2'd0;
  localparam logic [1:0] POS_HU = 2'd1;
  localparam logic [1:0] POS_MT = 2'd2;
  localparam logic [1:0] POS_MU = 2'd3;

  localparam logic [3:0] HT_MAX    = 4'd2;
  localparam logic [3:0] HU_MAX    = 4'd9;
  localparam logic [3:0] HU_MAX_20 = 4'd3;
  localparam logic [3:0] MT_MAX    = 4'd5;
  localparam logic [3:0] MU_MAX    = 4'd9;

endpackage

// File: rtl/time_edit_bcd_step.sv
// Combinational single-digit BCD step: increments or decrements one digit,
// wrapping between 0 and max. Simultaneous or absent pulses leave it unchanged.
module time_edit_bcd_step (
  input  logic [3:0] val_i,
  input  logic [3:0] max_i,
  input  logic       up_i,
  input  logic       down_i,
  output logic [3:0] val_o
);

  always_comb begin
    val_o = val_i;
    if (up_i && !down_i) begin
      val_o = (val_i >= max_i) ? 4'd0 : val_i + 4'd1;
    end else if (down_i && !up_i) begin
      val_o = (val_i == 4'd0) ? max_i : val_i - 4'd1;
    end
  end

endmodule

// File: rtl/time_edit.sv
// HH:MM digit editor: captures the running time, edits one BCD digit per
// cycle under cursor control, then returns the result with a commit strobe.
module time_edit
  import time_edit_pkg::*;
#(
  parameter int BLINK_W = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [1:0]  pos,
  input  logic        up,
  input  logic        down,
  input  logic [15:0] time_in,
  output logic [15:0] time_out,
  output logic        commit,
  output logic [3:0]  blank,
  output logic        editing,
  output logic [1:0]  dbg_state
);

  state_t              state_q, state_d;
  logic [15:0]         edit_q, edit_d;
  logic [BLINK_W-1:0]  blink_q, blink_d;

  logic       step_en;
  logic [3:0] ht_step, hu_step, mt_step, mu_step;
  logic [3:0] hu_max, hu_next;

  // Edits only apply while the session is still open; the en-drop cycle is ignored.
  assign step_en = (state_q == EDIT) && en;

  time_edit_bcd_step u_ht (
    .val_i  (edit_q[15:12]),
    .max_i  (HT_MAX),
    .up_i   (step_en && (pos == POS_HT) && up),
    .down_i (step_en && (pos == POS_HT) && down),
    .val_o  (ht_step)
  );

  // Hu range follows the post-edit Ht so the hour never leaves 00..23.
  assign hu_max = (ht_step == HT_MAX) ? HU_MAX_20 : HU_MAX;

  time_edit_bcd_step u_hu (
    .val_i  (edit_q[11:8]),
    .max_i  (hu_max),
    .up_i   (step_en && (pos == POS_HU) && up),
    .down_i (step_en && (pos == POS_HU) && down),
    .val_o  (hu_step)
  );

  assign hu_next = ((ht_step == HT_MAX) && (hu_step > HU_MAX_20)) ? HU_MAX_20 : hu_step;

  time_edit_bcd_step u_mt (
    .val_i  (edit_q[7:4]),
    .max_i  (MT_MAX),
    .up_i   (step_en && (pos == POS_MT) && up),
    .down_i (step_en && (pos == POS_MT) && down),
    .val_o  (mt_step)
  );

  time_edit_bcd_step u_mu (
    .val_i  (edit_q[3:0]),
    .max_i  (MU_MAX),
    .up_i   (step_en && (pos == POS_MU) && up),
    .down_i (step_en && (pos == POS_MU) && down),
    .val_o  (mu_step)
  );

  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    blink_d = blink_q + {{(BLINK_W-1){1'b0}}, 1'b1};
    case (state_q)
      IDLE: begin
        if (en) begin
          edit_d  = time_in;
          state_d = EDIT;
        end
      end
      EDIT: begin
        if (!en) state_d = COMMIT;
        else     edit_d  = {ht_step, hu_next, mt_step, mu_step};
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      edit_q  <= 16'h0000;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      edit_q  <= edit_d;
      blink_q <= blink_d;
    end
  end

  // commit is a one-cycle strobe with no back-pressure; time_out is valid while it is high.
  assign time_out  = edit_q;
  assign commit    = (state_q == COMMIT);
  assign editing   = (state_q == EDIT);
  assign dbg_state = state_q;
  assign blank     = editing ? ((4'b0001 << pos) & {4{blink_q[BLINK_W-1]}}) : 4'b0000;

endmodule

// File: tb/tb_time_edit.sv
// Directed bench for time_edit: capture, digit limits and wraps, commit,
// reset during edit and blink mask behaviour with a 4-bit blink counter.
module tb_time_edit;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  pos;
  logic        up;
  logic        down;
  logic [15:0] time_in;
  logic [15:0] time_out;
  logic        commit;
  logic [3:0]  blank;
  logic        editing;
  logic [1:0]  dbg_state;

  int n_pass  = 0;
  int n_total = 0;

  time_edit #(.BLINK_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .pos       (pos),
    .up        (up),
    .down      (down),
    .time_in   (time_in),
    .time_out  (time_out),
    .commit    (commit),
    .blank     (blank),
    .editing   (editing),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] p, input logic u, input logic d);
    pos  = p;
    up   = u;
    down = d;
    tick();
    up   = 1'b0;
    down = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; pos = 2'd0; up = 1'b0; down = 1'b0; time_in = 16'h0000;
    tick(); tick();
    reset = 1'b0;
    n_total++; if (time_out !== 16'h0000) $display("FAIL reset_time: got %h exp 0000", time_out); else n_pass++;
    n_total++; if (commit !== 1'b0) $display("FAIL reset_commit: got %b exp 0", commit); else n_pass++;
    n_total++; if (editing !== 1'b0) $display("FAIL reset_editing: got %b exp 0", editing); else n_pass++;
    n_total++; if (blank !== 4'b0000) $display("FAIL reset_blank: got %b exp 0000", blank); else n_pass++;
    n_total++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d exp 0", dbg_state); else n_pass++;
  endtask

  task automatic test_capture();
    time_in = 16'h1947;
    en = 1'b1;
    tick();
    n_total++; if (time_out !== 16'h1947) $display("FAIL capture_time: got %h exp 1947", time_out); else n_pass++;
    n_total++; if (editing !== 1'b1) $display("FAIL capture_editing: got %b exp 1", editing); else n_pass++;
    time_in = 16'h0000;
    tick();
    n_total++; if (time_out !== 16'h1947) $display("FAIL capture_hold: got %h exp 1947", time_out); else n_pass++;
  endtask

  task automatic test_hour_limit();
    pulse(2'd0, 1'b1, 1'b0);
    n_total++; if (time_out !== 16'h2347) $display("FAIL ht_up_clamp: got %h exp 2347", time_out); else n_pass++;
    pulse(2'd0, 1'b1, 1'b0);
    n_total++; if (time_out !== 16'h0347) $display("FAIL ht_wrap_up: got %h exp 0347", time_out); else n_pass++;
    pulse(2'd0, 1'b0, 1'b1);
    n_total++; if (time_out !== 16'h2347) $display("FAIL ht_wrap_down: got %h exp 2347", time_out); else n_pass++;
    pulse(2'd1, 1'b1, 1'b0);
    n_total++; if (time_out !== 16'h2047) $display("FAIL hu20_wrap_up: got %h exp 2047", time_out); else n_pass++;
    pulse(2'd1, 1'b0, 1'b1);
    n_total++; if (time_out !== 16'h2347) $display("FAIL hu20_wrap_down: got %h exp 2347", time_out); else n_pass++;
  endtask

  task automatic test_wrap();
    pulse(2'd3, 1'b1, 1'b0);
    pulse(2'd3, 1'b1, 1'b0);
    n_total++; if (time_out !== 16'h2349) $display("FAIL mu_up: got %h exp 2349", time_out); else n_pass++;
    pulse(2'd3, 1'b1, 1'b0);
    n_total++; if (time_out !== 16'h2340) $display("FAIL mu_wrap_nocarry: got %h exp 2340", time_out); else n_pass++;
    for (int i = 0; i < 4; i++) pulse(2'd2, 1'b0, 1'b1);
    n_total++; if (time_out !== 16'h2300) $display("FAIL mt_down: got %h exp 2300", time_out); else n_pass++;
    pulse(2'd2, 1'b0, 1'b1);
    n_total++; if (time_out !== 16'h2350) $display("FAIL mt_wrap_down: got %h exp 2350", time_out); else n_pass++;
    pulse(2'd2, 1'b1, 1'b1);
    n_total++; if (time_out !== 16'h2350) $display("FAIL both_pulses: got %h exp 2350", time_out); else n_pass++;
    pulse(2'd3, 1'b0, 1'b1);
    n_total++; if (time_out !== 16'h2359) $display("FAIL mu_wrap_down: got %h exp 2359", time_out); else n_pass++;
  endtask

  task automatic test_commit();
    en = 1'b0; pos = 2'd3; up = 1'b1;
    time_in = 16'h1947;
    tick();
    up = 1'b0;
    en = 1'b1;
    n_total++; if (commit !== 1'b1) $display("FAIL commit_high: got %b exp 1", commit); else n_pass++;
    n_total++; if (time_out !== 16'h2359) $display("FAIL commit_value: got %h exp 2359", time_out); else n_pass++;
    n_total++; if (editing !== 1'b0) $display("FAIL commit_editing: got %b exp 0", editing); else n_pass++;
    n_total++; if (dbg_state !== 2'd2) $display("FAIL commit_state: got %0d exp 2", dbg_state); else n_pass++;
    tick();
    n_total++; if (commit !== 1'b0) $display("FAIL commit_one_cycle: got %b exp 0", commit); else n_pass++;
    n_total++; if (editing !== 1'b0) $display("FAIL commit_to_idle: got %b exp 0", editing); else n_pass++;
    n_total++; if (time_out !== 16'h2359) $display("FAIL commit_hold: got %h exp 2359", time_out); else n_pass++;
    tick();
    n_total++; if (editing !== 1'b1) $display("FAIL recapture_editing: got %b exp 1", editing); else n_pass++;
    n_total++; if (time_out !== 16'h1947) $display("FAIL recapture_time: got %h exp 1947", time_out); else n_pass++;
  endtask

  task automatic test_reset_mid_edit();
    int commits;
    pulse(2'd0, 1'b1, 1'b0);
    pulse(2'd3, 1'b1, 1'b0);
    pulse(2'd3, 1'b1, 1'b0);
    pulse(2'd2, 1'b1, 1'b0);
    n_total++; if (time_out !== 16'h2359) $display("FAIL pre_reset_edit: got %h exp 2359", time_out); else n_pass++;
    reset = 1'b1;
    en = 1'b0;
    tick();
    reset = 1'b0;
    commits = (commit === 1'b1) ? 1 : 0;
    n_total++; if (time_out !== 16'h0000) $display("FAIL midreset_time: got %h exp 0000", time_out); else n_pass++;
    n_total++; if (editing !== 1'b0) $display("FAIL midreset_editing: got %b exp 0", editing); else n_pass++;
    n_total++; if (blank !== 4'b0000) $display("FAIL midreset_blank: got %b exp 0000", blank); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (commit === 1'b1) commits++;
    end
    n_total++; if (commits !== 0) $display("FAIL midreset_no_commit: got %0d exp 0", commits); else n_pass++;
  endtask

  task automatic test_blink();
    logic [3:0] prev;
    logic [3:0] first;
    logic [3:0] other;
    logic [3:0] exp_b;
    bit         found;
    time_in = 16'h1200;
    pos = 2'd1;
    en = 1'b1;
    tick();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev = blank;
      tick();
      if (blank !== prev) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL blink_toggle_found: got none exp toggle within 20"); else n_pass++;
    first = blank;
    other = (first == 4'b0010) ? 4'b0000 : 4'b0010;
    n_total++; if (first !== 4'b0010 && first !== 4'b0000) $display("FAIL blink_mask_value: got %b exp 0010 or 0000", first); else n_pass++;
    for (int k = 1; k < 16; k++) begin
      tick();
      exp_b = (k < 8) ? first : other;
      n_total++; if (blank !== exp_b) $display("FAIL blink_period_k%0d: got %b exp %b", k, blank, exp_b); else n_pass++;
    end
    // blank now equals 'other'; wait for the rising phase to get seven high cycles ahead
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev = blank;
      tick();
      if (prev === 4'b0000 && blank === 4'b0010) found = 1'b1;
    end
    n_total++; if (!found) $display("FAIL blink_rise_found: got none exp rise within 20"); else n_pass++;
    pos = 2'd3;
    #1;
    n_total++; if (blank !== 4'b1000) $display("FAIL blink_pos3_same_cycle: got %b exp 1000", blank); else n_pass++;
    pos = 2'd0;
    #1;
    n_total++; if (blank !== 4'b0001) $display("FAIL blink_pos0_same_cycle: got %b exp 0001", blank); else n_pass++;
    en = 1'b0;
    tick();
    n_total++; if (commit !== 1'b1) $display("FAIL blink_commit: got %b exp 1", commit); else n_pass++;
    n_total++; if (blank !== 4'b0000) $display("FAIL blink_blank_in_commit: got %b exp 0000", blank); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_hour_limit();
    test_wrap();
    test_commit();
    test_reset_mid_edit();
    test_blink();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
